mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum number of cycles spent waiting for DMEM_ACK (used only with MEM_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 VALID_IN  in  1  EXE outputs valid this cycle.
REQ-005 CRT_MEM_IN  in  5  [0] MEM_RD, [1] MEM_WR, [4:2] SIZE (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 CRT_WB_IN  in  2  WB control, passed through.
REQ-007 ALU_RESULT_IN  in  32  effective address / ALU value.
REQ-008 DATO_B_IN  in  32  store data.
REQ-009 INST_IN  in  5  destination register index.
REQ-010 STALL_OUT  out  1  high = upstream SHALL hold all inputs.
REQ-011 DMEM_REQ, DMEM_WE  out  1 each  memory request, write enable.
REQ-012 DMEM_ADDR  out  32  word address, bits [1:0] = 0.
REQ-013 DMEM_WDATA  out  32; DMEM_BE  out  4  byte enables.
REQ-014 DMEM_ACK  in  1; DMEM_RDATA  in  32  read data valid with ACK.
REQ-015 VALID_OUT, MISALIGN_OUT, BUS_ERR_OUT  out  1 each  WB-stage qualifiers.
REQ-016 READ_DATA_OUT, ALU_RESULT_OUT  out  32; INST_OUT  out  5; CRT_WB_OUT  out  2  registered to WB.

Function
REQ-017 FSM states: IDLE, BUSY; STALL_OUT SHALL equal (state == BUSY), combinational from state.
REQ-018 Inputs SHALL be sampled only in IDLE.
REQ-019 In IDLE with VALID_IN=1 and neither MEM_RD nor MEM_WR set: outputs registered next cycle with VALID_OUT=1 and READ_DATA_OUT=0 (1-cycle latency).
REQ-020 In IDLE with VALID_IN=1, an aligned access, and MEM_RD or MEM_WR set: register the request, enter BUSY, and assert DMEM_REQ from the next cycle.
REQ-021 DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA and DMEM_BE SHALL be held stable throughout BUSY.
REQ-022 DMEM_ACK in BUSY, including the first BUSY cycle: capture DMEM_RDATA and return to IDLE; VALID_OUT=1 on the following cycle; DMEM_ACK outside BUSY SHALL be ignored.
REQ-023 Store: BE = 0001<<A[1:0] (B), 0011<<A[1:0] (H), 1111 (W); WDATA = the byte replicated 4x, the halfword replicated 2x, or the full word.
REQ-024 Load: extract the lane selected by A[1:0]; B/H SHALL sign-extend, BU/HU SHALL zero-extend, W passes unchanged.
REQ-025 Misaligned (H/HU with A[0]=1; W with A[1:0]≠0): no DMEM_REQ; next cycle VALID_OUT=1, MISALIGN_OUT=1, READ_DATA_OUT=0.
REQ-026 MEM_RD and MEM_WR both set: the store SHALL be performed, the read ignored, and READ_DATA_OUT=0.
REQ-027 MISALIGN_OUT and BUS_ERR_OUT SHALL be single-cycle, aligned with VALID_OUT; VALID_OUT SHALL be a 1-cycle pulse per instruction.
REQ-028 VALID_IN=0 in IDLE: VALID_OUT=0 next cycle; data outputs hold their previous values.

Reset
REQ-029 rst SHALL force state=IDLE and set to 0: DMEM_REQ, DMEM_WE, DMEM_BE, VALID_OUT, MISALIGN_OUT, BUS_ERR_OUT, the timeout counter, and all data outputs.
REQ-030 rst during BUSY SHALL drop DMEM_REQ on the next edge and discard the pending access with no VALID_OUT; a late DMEM_ACK SHALL be ignored.

Configuration
REQ-031 Macro MEM_TIMEOUT_EN defined: count BUSY cycles; when the count reaches TIMEOUT_CYCLES without ACK, drop DMEM_REQ, return to IDLE, and pulse VALID_OUT with BUS_ERR_OUT=1 and READ_DATA_OUT=0.
REQ-032 MEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; BUS_ERR_OUT tied to 0.

Structure
REQ-033 Package mem_stage_pkg SHALL hold the state enum, SIZE codes, and CRT_MEM bit positions.
REQ-034 Sub-module load_aligner (combinational: RDATA, A[1:0], SIZE -> extended data) SHALL be instantiated once.

Verification
REQ-035 SW addr 0x100, data 0xDEADBEEF, ACK after 2 cycles -> DMEM_ADDR=0x100, BE=1111, STALL_OUT high for 3 cycles, VALID_OUT 1 cycle after ACK.
REQ-036 LB addr 0x103, RDATA 0x80FF_0000 -> READ_DATA_OUT=0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 SH addr 0x202, data 0x1234 -> BE=1100, WDATA=0x12341234; LW addr 0x202 -> no DMEM_REQ, MISALIGN_OUT=1.
REQ-038 ALU op (no RD/WR), ALU_RESULT_IN=0x5 -> ALU_RESULT_OUT=0x5, VALID_OUT next cycle, STALL_OUT stays 0.
REQ-039 rst asserted in BUSY, ACK arriving afterwards -> DMEM_REQ=0 next cycle, no VALID_OUT; with MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ACK -> BUS_ERR_OUT=1 after 4 BUSY cycles.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the memory-access pipeline stage:
//     - FSM state encoding (IDLE / BUSY)
//     - access SIZE codes carried in CRT_MEM[4:2]
//     - bit positions of the fields inside CRT_MEM
//     - small helpers that classify a SIZE code as byte / halfword access
//   Codes outside the five defined SIZE values (011, 110, 111) classify as
//   word accesses everywhere, so they can never produce a partial lane.
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int CRT_RD_BIT   = 0;
  localparam int CRT_WR_BIT   = 1;
  localparam int CRT_SIZE_LSB = 2;
  localparam int CRT_SIZE_MSB = 4;

  // Bit 2 of SIZE only selects zero-extension; bits [1:0] give the width.
  function automatic logic size_is_byte(input logic [2:0] size);
    return (size[1:0] == 2'b00);
  endfunction

  function automatic logic size_is_half(input logic [2:0] size);
    return (size[1:0] == 2'b01);
  endfunction

endpackage

// File: rtl/load_aligner.sv
// load_aligner
//   Combinational load-data formatter. Selects the byte / halfword lane of a
//   32-bit read word addressed by addr_lo and extends it to 32 bits.
//   Ports:
//     rdata    in  32  raw word returned by data memory
//     addr_lo  in  2   low address bits of the access (lane select)
//     size     in  3   access SIZE code (B, H, W, BU, HU)
//     data_out out 32  extended load value
//   B/H sign-extend, BU/HU zero-extend, W (and unlisted codes) pass through.
module load_aligner
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  output logic [31:0] data_out
);

  logic        [31:0] shifted;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    // Move the addressed lane down to bit 0.
    shifted = rdata >> {addr_lo, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = shifted[15:0];
    data_out = rdata;
    if (size_is_byte(size)) begin
      data_out = size[2] ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
    end else if (size_is_half(size)) begin
      data_out = size[2] ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   MEM pipeline stage: issues one data-memory access per load/store, stalls
//   upstream while the access is outstanding, and registers results for WB.
//   Optional feature: define MEM_TIMEOUT_EN to abort an access that receives
//   no DMEM_ACK within TIMEOUT_CYCLES BUSY cycles (reported via BUS_ERR_OUT).
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     VALID_IN            EXE result valid this cycle
//     CRT_MEM_IN[4:0]     [0] read, [1] write, [4:2] SIZE
//     CRT_WB_IN[1:0]      WB control, passed through
//     ALU_RESULT_IN[31:0] effective address / ALU value
//     DATO_B_IN[31:0]     store data
//     INST_IN[4:0]        destination register index
//     STALL_OUT           upstream must hold its inputs (state == BUSY)
//     DMEM_REQ/WE/ADDR/WDATA/BE   data-memory request, held through BUSY
//     DMEM_ACK, DMEM_RDATA        memory completion and read data
//     VALID_OUT, MISALIGN_OUT, BUS_ERR_OUT   one-cycle WB qualifiers
//     READ_DATA_OUT, ALU_RESULT_OUT, INST_OUT, CRT_WB_OUT  registered to WB
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        VALID_IN,
  input  logic [4:0]  CRT_MEM_IN,
  input  logic [1:0]  CRT_WB_IN,
  input  logic [31:0] ALU_RESULT_IN,
  input  logic [31:0] DATO_B_IN,
  input  logic [4:0]  INST_IN,
  output logic        STALL_OUT,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BE,
  input  logic        DMEM_ACK,
  input  logic [31:0] DMEM_RDATA,
  output logic        VALID_OUT,
  output logic        MISALIGN_OUT,
  output logic        BUS_ERR_OUT,
  output logic [31:0] READ_DATA_OUT,
  output logic [31:0] ALU_RESULT_OUT,
  output logic [4:0]  INST_OUT,
  output logic [1:0]  CRT_WB_OUT
);

  function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] alo);
    logic [3:0] be;
    be = 4'b1111;
    if (size_is_byte(size))      be = 4'b0001 << alo;
    else if (size_is_half(size)) be = 4'b0011 << alo;
    return be;
  endfunction

  // Replicating the datum across lanes lets BE alone select the target bytes.
  function automatic logic [31:0] store_wdata(input logic [2:0] size, input logic [31:0] d);
    logic [31:0] w;
    w = d;
    if (size_is_byte(size))      w = {4{d[7:0]}};
    else if (size_is_half(size)) w = {2{d[15:0]}};
    return w;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] alo);
    logic mis;
    mis = (alo != 2'b00);
    if (size_is_byte(size))      mis = 1'b0;
    else if (size_is_half(size)) mis = alo[0];
    return mis;
  endfunction

  state_e      state_q, state_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] read_data_q, read_data_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [4:0]  inst_q, inst_d;
  logic [1:0]  crt_wb_q, crt_wb_d;

  // Pending access bookkeeping, only meaningful while BUSY.
  logic [31:0] pend_alu_q, pend_alu_d;
  logic [2:0]  pend_size_q, pend_size_d;
  logic        pend_load_q, pend_load_d;
  logic [4:0]  pend_inst_q, pend_inst_d;
  logic [1:0]  pend_wb_q, pend_wb_d;

  logic        rd_in, wr_in;
  logic [2:0]  size_in;
  logic [31:0] load_data;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             bus_err_q, bus_err_d;
  assign BUS_ERR_OUT = bus_err_q;
`else
  logic cfg_unused;
  assign cfg_unused  = (TIMEOUT_CYCLES == 0);
  assign BUS_ERR_OUT = 1'b0;
`endif

  assign rd_in   = CRT_MEM_IN[CRT_RD_BIT];
  assign wr_in   = CRT_MEM_IN[CRT_WR_BIT];
  assign size_in = CRT_MEM_IN[CRT_SIZE_MSB:CRT_SIZE_LSB];

  load_aligner u_load_aligner (
    .rdata    (DMEM_RDATA),
    .addr_lo  (pend_alu_q[1:0]),
    .size     (pend_size_q),
    .data_out (load_data)
  );

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    valid_d      = 1'b0;
    misalign_d   = 1'b0;
    read_data_d  = read_data_q;
    alu_res_d    = alu_res_q;
    inst_d       = inst_q;
    crt_wb_d     = crt_wb_q;
    pend_alu_d   = pend_alu_q;
    pend_size_d  = pend_size_q;
    pend_load_d  = pend_load_q;
    pend_inst_d  = pend_inst_q;
    pend_wb_d    = pend_wb_q;
`ifdef MEM_TIMEOUT_EN
    bus_err_d    = 1'b0;
    tmo_cnt_d    = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (VALID_IN) begin
          if (!(rd_in || wr_in) || is_misaligned(size_in, ALU_RESULT_IN[1:0])) begin
            // Non-memory op or rejected access: complete in one cycle.
            valid_d     = 1'b1;
            misalign_d  = (rd_in || wr_in);
            read_data_d = 32'h0;
            alu_res_d   = ALU_RESULT_IN;
            inst_d      = INST_IN;
            crt_wb_d    = CRT_WB_IN;
          end else begin
            state_d      = ST_BUSY;
            dmem_req_d   = 1'b1;
            dmem_we_d    = wr_in;
            dmem_addr_d  = {ALU_RESULT_IN[31:2], 2'b00};
            dmem_be_d    = store_be(size_in, ALU_RESULT_IN[1:0]);
            dmem_wdata_d = wr_in ? store_wdata(size_in, DATO_B_IN) : 32'h0;
            pend_alu_d   = ALU_RESULT_IN;
            pend_size_d  = size_in;
            // A combined read+write is performed as a store only.
            pend_load_d  = rd_in && !wr_in;
            pend_inst_d  = INST_IN;
            pend_wb_d    = CRT_WB_IN;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_d    = '0;
`endif
          end
        end
      end
      ST_BUSY: begin
        if (DMEM_ACK) begin
          state_d     = ST_IDLE;
          dmem_req_d  = 1'b0;
          dmem_we_d   = 1'b0;
          dmem_be_d   = 4'b0000;
          valid_d     = 1'b1;
          read_data_d = pend_load_q ? load_data : 32'h0;
          alu_res_d   = pend_alu_q;
          inst_d      = pend_inst_q;
          crt_wb_d    = pend_wb_q;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d     = ST_IDLE;
          dmem_req_d  = 1'b0;
          dmem_we_d   = 1'b0;
          dmem_be_d   = 4'b0000;
          valid_d     = 1'b1;
          bus_err_d   = 1'b1;
          read_data_d = 32'h0;
          alu_res_d   = pend_alu_q;
          inst_d      = pend_inst_q;
          crt_wb_d    = pend_wb_q;
        end else begin
          tmo_cnt_d   = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_wdata_q <= 32'h0;
      dmem_be_q    <= 4'b0000;
      valid_q      <= 1'b0;
      misalign_q   <= 1'b0;
      read_data_q  <= 32'h0;
      alu_res_q    <= 32'h0;
      inst_q       <= 5'h0;
      crt_wb_q     <= 2'b00;
`ifdef MEM_TIMEOUT_EN
      bus_err_q    <= 1'b0;
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      valid_q      <= valid_d;
      misalign_q   <= misalign_d;
      read_data_q  <= read_data_d;
      alu_res_q    <= alu_res_d;
      inst_q       <= inst_d;
      crt_wb_q     <= crt_wb_d;
`ifdef MEM_TIMEOUT_EN
      bus_err_q    <= bus_err_d;
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  // Pending fields are only consumed while BUSY, which reset always leaves.
  always_ff @(posedge clk) begin
    pend_alu_q  <= pend_alu_d;
    pend_size_q <= pend_size_d;
    pend_load_q <= pend_load_d;
    pend_inst_q <= pend_inst_d;
    pend_wb_q   <= pend_wb_d;
  end

  assign STALL_OUT      = (state_q == ST_BUSY);
  assign DMEM_REQ       = dmem_req_q;
  assign DMEM_WE        = dmem_we_q;
  assign DMEM_ADDR      = dmem_addr_q;
  assign DMEM_WDATA     = dmem_wdata_q;
  assign DMEM_BE        = dmem_be_q;
  assign VALID_OUT      = valid_q;
  assign MISALIGN_OUT   = misalign_q;
  assign READ_DATA_OUT  = read_data_q;
  assign ALU_RESULT_OUT = alu_res_q;
  assign INST_OUT       = inst_q;
  assign CRT_WB_OUT     = crt_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
//   Directed bench for mem_stage. Stimulus pushes the expected WB result
//   (including the cycle it must appear in) onto a scoreboard queue; a
//   monitor on the falling edge pops and compares on every VALID_OUT.
//   With MEM_TIMEOUT_EN defined the bus-timeout path is exercised instead
//   of the long-wait path.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        VALID_IN = 1'b0;
  logic [4:0]  CRT_MEM_IN = '0;
  logic [1:0]  CRT_WB_IN = '0;
  logic [31:0] ALU_RESULT_IN = '0;
  logic [31:0] DATO_B_IN = '0;
  logic [4:0]  INST_IN = '0;
  logic        STALL_OUT, DMEM_REQ, DMEM_WE;
  logic [31:0] DMEM_ADDR, DMEM_WDATA;
  logic [3:0]  DMEM_BE;
  logic        DMEM_ACK = 1'b0;
  logic [31:0] DMEM_RDATA = '0;
  logic        VALID_OUT, MISALIGN_OUT, BUS_ERR_OUT;
  logic [31:0] READ_DATA_OUT, ALU_RESULT_OUT;
  logic [4:0]  INST_OUT;
  logic [1:0]  CRT_WB_OUT;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .VALID_IN(VALID_IN), .CRT_MEM_IN(CRT_MEM_IN),
    .CRT_WB_IN(CRT_WB_IN), .ALU_RESULT_IN(ALU_RESULT_IN), .DATO_B_IN(DATO_B_IN),
    .INST_IN(INST_IN), .STALL_OUT(STALL_OUT), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
    .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE),
    .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA), .VALID_OUT(VALID_OUT),
    .MISALIGN_OUT(MISALIGN_OUT), .BUS_ERR_OUT(BUS_ERR_OUT),
    .READ_DATA_OUT(READ_DATA_OUT), .ALU_RESULT_OUT(ALU_RESULT_OUT),
    .INST_OUT(INST_OUT), .CRT_WB_OUT(CRT_WB_OUT)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  inst;
    logic [1:0]  wb;
    logic        mis;
    logic        berr;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push(input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] inst,
                      input logic [1:0] wb, input logic mis, input logic berr);
    exp_t e;
    e.rd = rd; e.alu = alu; e.inst = inst; e.wb = wb; e.mis = mis; e.berr = berr;
    e.due = cyc;
    sb_q.push_back(e);
  endtask

  // Present one instruction for a single IDLE cycle.
  task automatic issue(input logic [4:0] crt, input logic [1:0] wb, input logic [31:0] alu,
                       input logic [31:0] b, input logic [4:0] inst);
    VALID_IN = 1'b1; CRT_MEM_IN = crt; CRT_WB_IN = wb;
    ALU_RESULT_IN = alu; DATO_B_IN = b; INST_IN = inst;
    @(posedge clk); #1;
    VALID_IN = 1'b0;
  endtask

  // Hold BUSY for delay cycles then ACK; junk upstream inputs must be ignored.
  task automatic serve(input int delay, input logic [31:0] rdata, input logic [31:0] e_addr,
                       input logic [3:0] e_be, input logic [31:0] e_wd, input logic e_we);
    for (int i = 0; i <= delay; i++) begin
      VALID_IN = 1'b1; CRT_MEM_IN = 5'b00000; ALU_RESULT_IN = 32'hBAD0BAD0; INST_IN = 5'd31;
      DMEM_ACK   = (i == delay);
      DMEM_RDATA = (i == delay) ? rdata : 32'h5A5A5A5A;
      @(negedge clk);
      chk("busy_stall", {31'h0, STALL_OUT}, 32'h1);
      chk("busy_req", {31'h0, DMEM_REQ}, 32'h1);
      chk("busy_we", {31'h0, DMEM_WE}, {31'h0, e_we});
      chk("busy_addr", DMEM_ADDR, e_addr);
      chk("busy_be", {28'h0, DMEM_BE}, {28'h0, e_be});
      chk("busy_wdata", DMEM_WDATA, e_wd);
      @(posedge clk); #1;
    end
    DMEM_ACK = 1'b0; VALID_IN = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (VALID_OUT) begin
        if (sb_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_valid: got VALID_OUT=1 expected none (cycle %0d)", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("valid_cycle", 32'(cyc), 32'(mon_e.due));
          chk("read_data", READ_DATA_OUT, mon_e.rd);
          chk("alu_result", ALU_RESULT_OUT, mon_e.alu);
          chk("inst", {27'h0, INST_OUT}, {27'h0, mon_e.inst});
          chk("crt_wb", {30'h0, CRT_WB_OUT}, {30'h0, mon_e.wb});
          chk("misalign", {31'h0, MISALIGN_OUT}, {31'h0, mon_e.mis});
          chk("bus_err", {31'h0, BUS_ERR_OUT}, {31'h0, mon_e.berr});
        end
      end else begin
        chk("misalign_idle", {31'h0, MISALIGN_OUT}, 32'h0);
        chk("bus_err_idle", {31'h0, BUS_ERR_OUT}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_stall", {31'h0, STALL_OUT}, 32'h0);
    chk("rst_req", {31'h0, DMEM_REQ}, 32'h0);
    chk("rst_we", {31'h0, DMEM_WE}, 32'h0);
    chk("rst_be", {28'h0, DMEM_BE}, 32'h0);
    chk("rst_valid", {31'h0, VALID_OUT}, 32'h0);
    chk("rst_read_data", READ_DATA_OUT, 32'h0);
    chk("rst_alu", ALU_RESULT_OUT, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    // ALU op: one-cycle latency, never stalls
    issue(5'b00000, 2'b11, 32'h5, 32'hFFFF, 5'd7);
    push(32'h0, 32'h5, 5'd7, 2'b11, 1'b0, 1'b0);
    @(negedge clk);
    chk("alu_stall", {31'h0, STALL_OUT}, 32'h0);
    chk("alu_req", {31'h0, DMEM_REQ}, 32'h0);

    // SW 0x100, ACK after 2 cycles -> 3 stall cycles
    issue(5'b01010, 2'b10, 32'h100, 32'hDEADBEEF, 5'd8);
    serve(2, 32'h0BADF00D, 32'h100, 4'b1111, 32'hDEADBEEF, 1'b1);
    push(32'h0, 32'h100, 5'd8, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    chk("sw_stall_end", {31'h0, STALL_OUT}, 32'h0);
    chk("sw_req_end", {31'h0, DMEM_REQ}, 32'h0);

    // LB / LBU at 0x103, ACK in first BUSY cycle for LB
    issue(5'b00001, 2'b01, 32'h103, 32'h0, 5'd10);
    serve(0, 32'h80FF0000, 32'h100, 4'b1000, 32'h0, 1'b0);
    push(32'hFFFFFF80, 32'h103, 5'd10, 2'b01, 1'b0, 1'b0);
    issue(5'b10001, 2'b01, 32'h103, 32'h0, 5'd11);
    serve(1, 32'h80FF0000, 32'h100, 4'b1000, 32'h0, 1'b0);
    push(32'h00000080, 32'h103, 5'd11, 2'b01, 1'b0, 1'b0);

    // SH 0x202: halfword replicated, upper lanes enabled
    issue(5'b00110, 2'b00, 32'h202, 32'hABCD1234, 5'd0);
    serve(1, 32'hFFFFFFFF, 32'h200, 4'b1100, 32'h12341234, 1'b1);
    push(32'h0, 32'h202, 5'd0, 2'b00, 1'b0, 1'b0);

    // LW 0x202 misaligned: no request
    issue(5'b01001, 2'b01, 32'h202, 32'h0, 5'd12);
    push(32'h0, 32'h202, 5'd12, 2'b01, 1'b1, 1'b0);
    @(negedge clk);
    chk("lw_mis_req", {31'h0, DMEM_REQ}, 32'h0);
    chk("lw_mis_stall", {31'h0, STALL_OUT}, 32'h0);

    // LH 0x206 sign-extends, LHU 0x204 zero-extends
    issue(5'b00101, 2'b01, 32'h206, 32'h0, 5'd13);
    serve(0, 32'h80017FFF, 32'h204, 4'b1100, 32'h0, 1'b0);
    push(32'hFFFF8001, 32'h206, 5'd13, 2'b01, 1'b0, 1'b0);
    issue(5'b10101, 2'b01, 32'h204, 32'h0, 5'd14);
    serve(2, 32'h1234F00D, 32'h204, 4'b0011, 32'h0, 1'b0);
    push(32'h0000F00D, 32'h204, 5'd14, 2'b01, 1'b0, 1'b0);

    // RD+WR together: store performed, read data discarded
    issue(5'b01011, 2'b11, 32'h400, 32'h11223344, 5'd15);
    serve(0, 32'hFFFFFFFF, 32'h400, 4'b1111, 32'h11223344, 1'b1);
    push(32'h0, 32'h400, 5'd15, 2'b11, 1'b0, 1'b0);

    // SB 0x101
    issue(5'b00010, 2'b00, 32'h101, 32'hFFFFFFA5, 5'd16);
    serve(0, 32'h0, 32'h100, 4'b0010, 32'hA5A5A5A5, 1'b1);
    push(32'h0, 32'h101, 5'd16, 2'b00, 1'b0, 1'b0);

    // LHU 0x001 misaligned
    issue(5'b10101, 2'b10, 32'h001, 32'h0, 5'd17);
    push(32'h0, 32'h001, 5'd17, 2'b10, 1'b1, 1'b0);
    @(negedge clk);
    chk("lhu_mis_req", {31'h0, DMEM_REQ}, 32'h0);

    // LW 0x300 then an idle cycle: outputs hold
    issue(5'b01001, 2'b01, 32'h300, 32'h0, 5'd18);
    serve(1, 32'hCAFEF00D, 32'h300, 4'b1111, 32'h0, 1'b0);
    push(32'hCAFEF00D, 32'h300, 5'd18, 2'b01, 1'b0, 1'b0);
    VALID_IN = 1'b0; CRT_MEM_IN = 5'b01001; ALU_RESULT_IN = 32'h777; INST_IN = 5'd1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_read_data", READ_DATA_OUT, 32'hCAFEF00D);
    chk("hold_alu", ALU_RESULT_OUT, 32'h300);
    chk("hold_inst", {27'h0, INST_OUT}, 32'd18);
    chk("hold_req", {31'h0, DMEM_REQ}, 32'h0);

`ifdef MEM_TIMEOUT_EN
    // No ACK: abort after 4 BUSY cycles with BUS_ERR_OUT
    issue(5'b01001, 2'b10, 32'h500, 32'h0, 5'd9);
    for (int i = 0; i < 4; i++) begin
      VALID_IN = 1'b1; CRT_MEM_IN = 5'b00000; ALU_RESULT_IN = 32'hBAD0BAD0;
      @(negedge clk);
      chk("tmo_stall", {31'h0, STALL_OUT}, 32'h1);
      chk("tmo_req", {31'h0, DMEM_REQ}, 32'h1);
      @(posedge clk); #1;
    end
    VALID_IN = 1'b0;
    push(32'h0, 32'h500, 5'd9, 2'b10, 1'b0, 1'b1);
    @(negedge clk);
    chk("tmo_stall_end", {31'h0, STALL_OUT}, 32'h0);
    chk("tmo_req_end", {31'h0, DMEM_REQ}, 32'h0);
`else
    // Long wait: BUSY persists until ACK arrives
    issue(5'b01001, 2'b10, 32'h500, 32'h0, 5'd9);
    serve(9, 32'h01020304, 32'h500, 4'b1111, 32'h0, 1'b0);
    push(32'h01020304, 32'h500, 5'd9, 2'b10, 1'b0, 1'b0);
`endif

    // Reset while BUSY, late ACK must be ignored
    issue(5'b01001, 2'b01, 32'h600, 32'h0, 5'd3);
    @(negedge clk);
    chk("rstb_req_before", {31'h0, DMEM_REQ}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstb_req", {31'h0, DMEM_REQ}, 32'h0);
    chk("rstb_stall", {31'h0, STALL_OUT}, 32'h0);
    chk("rstb_read_data", READ_DATA_OUT, 32'h0);
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'hFFFFFFFF;
    @(posedge clk); #1;
    DMEM_ACK = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstb_read_data_late", READ_DATA_OUT, 32'h0);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
